fetch_controller: RTL
=====================

# fetch_controller

Sequences the 256 x 8 asynchronous instruction ROM for the 8-bit RISC CPU. Drives the ROM address from an internal program counter and assembles 1-byte and 2-byte instructions (opcode + immediate). Holds each assembled instruction in an output register under a valid/ready handshake to the decode stage. Also handles branch redirects and HLT, and sits between the instruction memory and the decoder/control unit.

## Interface
- RESET_PC, 8'h00, program counter value after reset.
- TWO_BYTE_OPS, 16'h3200, bitmask indexed by opcode nibble `[7:4]`; a set bit marks a 2-byte instruction.
  - Default sets bit 9 (LDI, 1001), bit 12 (JMP, 1100) and bit 13 (JZ, 1101).
- HLT_OP, 4'b1110, opcode nibble that halts fetch.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- imem_addr  out  8  ROM address.
- imem_data  in  8  ROM data; combinational from imem_addr in the same cycle.
- instr_valid  out  1  assembled instruction available.
- instr_ready  in  1  decoder accepts the instruction this cycle.
- instr_op  out  8  opcode byte.
- instr_imm  out  8  immediate byte; 8'h00 for 1-byte instructions.
- instr_pc  out  8  address of the opcode byte.
- instr_len2  out  1  instruction is 2 bytes.
- redirect_valid  in  1  load a new PC (branch taken or restart).
- redirect_addr  in  8  target PC.
- halted  out  1  fetch stopped by HLT.

## Operation
- States: FETCH_OP, FETCH_IMM, PRESENT, HALT.
- imem_addr is combinational:
  - FETCH_OP: pc.
  - FETCH_IMM: pc+1 mod 256.
  - PRESENT / HALT: pc.
- FETCH_OP:
  - Capture imem_data into instr_op, clear instr_imm, set instr_pc = pc.
  - If TWO_BYTE_OPS[imem_data[7:4]] is set: instr_len2 = 1, next state FETCH_IMM.
  - Otherwise: instr_len2 = 0, next state PRESENT.
- FETCH_IMM: capture imem_data into instr_imm, next state PRESENT.
- PRESENT: instr_valid = 1; instr_op, instr_imm, instr_pc and instr_len2 are held stable until accepted.
- Accept (instr_valid & instr_ready):
  - If instr_op[7:4] == HLT_OP: next state HALT, halted = 1, pc unchanged (points at the HLT).
  - Otherwise: pc += (instr_len2 ? 2 : 1) mod 256, next state FETCH_OP.
- HALT: instr_valid = 0; remains in HALT until redirect_valid.
- Redirect has priority over everything, in any state including HALT:
  - Next edge: pc = redirect_addr, state FETCH_OP, instr_valid = 0, halted = 0.
  - Any partially assembled or unaccepted instruction is discarded.
  - Redirect in the same cycle as an accept: the accept counts as completed (the decoder consumed it), and redirect still sets pc.
- Wrap-around:
  - pc arithmetic is mod 256.
  - A 2-byte opcode at 8'hFF takes its immediate from address 8'h00.
  - Accepting it sets pc to 8'h01.
- Byte 8'h00 is treated as a 1-byte instruction (NOP) like any other opcode.

## Timing
- Reset (async assert, sync use after deassert):
  - state FETCH_OP, pc = RESET_PC, imem_addr = RESET_PC.
  - instr_valid = 0, instr_op = instr_imm = instr_pc = 8'h00, instr_len2 = 0, halted = 0.
- Reset mid-instruction aborts immediately; all outputs take reset values asynchronously.
- Latency counts edges after entering FETCH_OP:
  - 1-byte instruction: instr_valid high after 1 edge.
  - 2-byte instruction: instr_valid high after 2 edges.
- Accept edge: instr_valid drops on the same edge that moves the state to FETCH_OP.
  - Zero-stall throughput: one 1-byte instruction per 2 cycles, one 2-byte instruction per 3 cycles.
- instr_ready low holds PRESENT indefinitely; no output changes, imem_addr stays at pc.
- Redirect: instr_valid low from the next edge; first redirected instruction valid 1 or 2 edges after that.
- halted rises on the HLT accept edge and falls on the redirect edge.

## Test plan
- Sample program at 0 with instr_ready = 1:
  - LDI R0,5 → instr_op 8'h90, instr_imm 8'h05, instr_pc 0, instr_len2 1, instr_valid high after edge 2.
  - ADD R0,R1 → instr_op 8'h11, instr_imm 0, instr_pc 4.
  - ST R0,R3 → instr_pc 10.
  - HLT → instr_pc 11; halted = 1 after its accept; no further instr_valid.
- Backpressure:
  - Hold instr_ready = 0 for 5 cycles at pc 2.
  - instr_valid stays 1; instr_op 8'h94 / instr_imm 8'h03 stable.
  - On release, next instruction is at pc 4.
- Redirect:
  - Assert redirect_valid, addr 8'h07, during FETCH_IMM of the LDI at pc 5.
  - The LDI is never presented; next presented is SUB (8'h22) at instr_pc 7.
- Simultaneous accept + redirect to 8'h00:
  - The accepted instruction is not re-presented.
  - Next instr_pc = 0.
- Wrap: place 8'h90 at 8'hFF and 8'h5A at 8'h00, redirect to 8'hFF.
  - instr_imm 8'h5A; after accept, next instr_pc = 8'h01.
- Halt/restart and async reset:
  - Redirect out of HALT to 0 clears halted and restarts fetch.
  - rst_n low while in PRESENT clears instr_valid immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer for the 8-bit RISC CPU: walks the async ROM,
// assembles 1- or 2-byte instructions and presents them to decode with valid/ready.
module fetch_controller #(
  parameter logic [7:0]  RESET_PC     = 8'h00,
  parameter logic [15:0] TWO_BYTE_OPS = 16'h3200,
  parameter logic [3:0]  HLT_OP       = 4'b1110
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_data,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [7:0] instr_op,
  output logic [7:0] instr_imm,
  output logic [7:0] instr_pc,
  output logic       instr_len2,
  input  logic       redirect_valid,
  input  logic [7:0] redirect_addr,
  output logic       halted
);

  typedef enum logic [1:0] {
    FETCH_OP  = 2'd0,
    FETCH_IMM = 2'd1,
    PRESENT   = 2'd2,
    HALT      = 2'd3
  } state_t;

  state_t     state, state_next;
  logic [7:0] pc, pc_next;
  logic       halted_next;
  logic       accept;
  logic       op_is_len2;

  assign instr_valid = (state == PRESENT);
  assign accept      = instr_valid && instr_ready;
  assign op_is_len2  = TWO_BYTE_OPS[imem_data[7:4]];
  assign imem_addr   = (state == FETCH_IMM) ? pc + 8'd1 : pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= FETCH_OP;
      pc     <= RESET_PC;
      halted <= 1'b0;
    end else begin
      state  <= state_next;
      pc     <= pc_next;
      halted <= halted_next;
    end
  end

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    halted_next = halted;
    case (state)
      FETCH_OP:  state_next = op_is_len2 ? FETCH_IMM : PRESENT;
      FETCH_IMM: state_next = PRESENT;
      PRESENT: begin
        if (accept) begin
          if (instr_op[7:4] == HLT_OP) begin
            // pc stays on the HLT so a restart can inspect where fetch stopped
            state_next  = HALT;
            halted_next = 1'b1;
          end else begin
            state_next = FETCH_OP;
            pc_next    = pc + (instr_len2 ? 8'd2 : 8'd1);
          end
        end
      end
      HALT:      state_next = HALT;
      default:   state_next = FETCH_OP;
    endcase
    // Redirect overrides everything; an accept in the same cycle is still consumed.
    if (redirect_valid) begin
      state_next  = FETCH_OP;
      pc_next     = redirect_addr;
      halted_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_op   <= 8'h00;
      instr_imm  <= 8'h00;
      instr_pc   <= 8'h00;
      instr_len2 <= 1'b0;
    end else if (!redirect_valid) begin
      case (state)
        FETCH_OP: begin
          instr_op   <= imem_data;
          instr_imm  <= 8'h00;
          instr_pc   <= pc;
          instr_len2 <= op_is_len2;
        end
        FETCH_IMM: instr_imm <= imem_data;
        default: ;
      endcase
    end
  end

endmodule
